// File: rtl/br_pkg.sv
// Shared encodings for the Mini SRC branch unit: branch opcode, C2 condition
// codes, FSM states and the branch-format instruction layout.
package br_pkg;

  localparam logic [4:0] OP_BR = 5'b10010;

  typedef enum logic [1:0] {
    BR_ZR = 2'b00,
    BR_NZ = 2'b01,
    BR_PL = 2'b10,
    BR_MI = 2'b11
  } c2_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    EVAL   = 2'b01,
    CALC   = 2'b10,
    COMMIT = 2'b11
  } state_e;

  // Branch-format IR: opcode, Ra select, two don't-care bits, C2, C offset.
  typedef struct packed {
    logic [4:0]  opcode;
    logic [3:0]  ra_sel;
    logic [1:0]  rsvd;
    c2_e         c2;
    logic [18:0] c_off;
  } br_ir_t;

endpackage

// File: rtl/br_cond_eval.sv
// Branch condition evaluator: C2 against Ra, purely combinational (0 cycles).
// No flow control; output follows inputs.
module br_cond_eval
  import br_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [1:0]   c2,
  input  logic [W-1:0] ra,
  output logic         cond
);

  always_comb begin
    cond = 1'b0;
    case (c2_e'(c2))
      BR_ZR: cond = (ra == '0);
      BR_NZ: cond = (ra != '0);
      BR_PL: cond = ~ra[W-1];
      BR_MI: cond = ra[W-1];
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_pc_ctrl.sv
// Branch execution unit and PC owner: 3 cycles start->PC update, start ignored while busy.
// Optional BRANCH_STATS_EN adds saturating branch/taken counters.
module branch_pc_ctrl
  import br_pkg::*;
#(
  parameter int                  PC_WIDTH  = 32,
  parameter int                  OFF_WIDTH = 19,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic                inc_pc,
  input  logic [31:0]         ir,
  input  logic [PC_WIDTH-1:0] ra_value,
  output logic                busy,
  output logic                done,
  output logic                taken,
  output logic [PC_WIDTH-1:0] pc
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]         br_count,
  output logic [15:0]         taken_count
`endif
);

  state_e              state_q, state_d;
  br_ir_t              ir_f;
  logic                is_br;
  logic                cond;
  logic                con_q;
  logic                done_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] target_q;
  logic [PC_WIDTH-1:0] off_sext;
  logic                unused_ir;

  assign ir_f      = br_ir_t'(ir);
  assign is_br     = (ir_f.opcode == OP_BR);
  assign off_sext  = {{(PC_WIDTH-OFF_WIDTH){ir[OFF_WIDTH-1]}}, ir[OFF_WIDTH-1:0]};
  assign unused_ir = ^{ir_f.ra_sel, ir_f.rsvd, ir_f.c_off};

  br_cond_eval #(.W(PC_WIDTH)) u_cond (
    .c2   (ir_f.c2),
    .ra   (ra_value),
    .cond (cond)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = is_br ? EVAL : COMMIT;
      EVAL:    state_d = CALC;
      CALC:    state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      con_q    <= 1'b0;
      target_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == COMMIT);
      case (state_q)
        IDLE: begin
          // A non-branch opcode skips EVAL, so clear con_q here to keep PC untouched.
          if (start) begin
            if (!is_br) con_q <= 1'b0;
          end else if (inc_pc) begin
            pc_q <= pc_q + PC_WIDTH'(1);
          end
        end
        EVAL:    con_q    <= cond;
        CALC:    target_q <= pc_q + off_sext;
        COMMIT:  if (con_q) pc_q <= target_q;
        default: ;
      endcase
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign taken = con_q;
  assign pc    = pc_q;

`ifdef BRANCH_STATS_EN
  logic is_br_q;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      is_br_q     <= 1'b0;
      br_count    <= '0;
      taken_count <= '0;
    end else begin
      if (state_q == IDLE && start) is_br_q <= is_br;
      if (state_q == COMMIT && is_br_q) begin
        if (br_count != 16'hFFFF) br_count <= br_count + 16'd1;
        if (con_q && taken_count != 16'hFFFF) taken_count <= taken_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Scoreboarded random/directed bench for branch_pc_ctrl (BRANCH_STATS_EN aware).
module tb_branch_pc_ctrl;

  localparam logic [4:0] OPB = 5'b10010;

  logic        clock = 1'b0;
  logic        clear, start, inc_pc;
  logic [31:0] ir, ra_value;
  logic        busy, done, taken;
  logic [31:0] pc;
`ifdef BRANCH_STATS_EN
  logic [15:0] br_count, taken_count;
`endif

  branch_pc_ctrl dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .inc_pc      (inc_pc),
    .ir          (ir),
    .ra_value    (ra_value),
    .busy        (busy),
    .done        (done),
    .taken       (taken),
    .pc          (pc)
`ifdef BRANCH_STATS_EN
    ,
    .br_count    (br_count),
    .taken_count (taken_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    bit          taken;
    int          at;
    bit          br;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [31:0] pc_model = '0;
  int          br_model = 0;
  int          tk_model = 0;
  bit          prev_done = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: pops an expectation on every done pulse; PC must not move while busy.
  always @(negedge clock) begin
    exp_t e;
    if (clear) begin
      if (done) begin
        chk("done_one_cycle", 64'(prev_done), 0);
        chk("busy_low_at_done", 64'(busy), 0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("pc_after_commit", 64'(pc), 64'(e.pc));
          chk("taken", 64'(taken), 64'(e.taken));
          chk("done_cycle", 64'(cyc), 64'(e.at));
          pc_model = e.pc;
          if (e.br) begin
            if (br_model < 65535) br_model++;
            if (e.taken && tk_model < 65535) tk_model++;
          end
`ifdef BRANCH_STATS_EN
          chk("br_count", 64'(br_count), 64'(br_model));
          chk("taken_count", 64'(taken_count), 64'(tk_model));
`endif
        end
      end else if (busy) begin
        chk("pc_hold_busy", 64'(pc), 64'(pc_model));
      end
    end
    prev_done = done;
  end

  task automatic do_reset();
    @(negedge clock);
    clear = 1'b0;
    sb.delete();
    @(negedge clock);
    clear = 1'b1;
    pc_model = '0;
    br_model = 0;
    tk_model = 0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (sb.size() == 0 && !busy) begin
        ok = 1;
        break;
      end
    end
    chk("idle_timeout", 64'(ok), 1);
    if (!ok) do_reset();
  endtask

  task automatic incs(input int n);
    @(negedge clock);
    inc_pc = 1'b1;
    repeat (n) @(posedge clock);
    @(negedge clock);
    inc_pc = 1'b0;
    pc_model = pc_model + 32'(n);
    chk("inc_pc", 64'(pc), 64'(pc_model));
  endtask

  function automatic logic [31:0] mk_br(input logic [1:0] c2, input logic [18:0] off);
    logic [5:0] junk;
    junk = 6'($urandom);
    return {OPB, junk, c2, off};
  endfunction

  // Reference: decode fields, evaluate condition and target from plain arithmetic.
  task automatic issue(input logic [31:0] irv, input logic [31:0] rav, input bit ign);
    exp_t e;
    bit   isbr, c;
    int   off;
    @(negedge clock);
    isbr = (irv[31:27] == OPB);
    case (irv[20:19])
      2'd0:    c = (rav == 0);
      2'd1:    c = (rav != 0);
      2'd2:    c = ($signed(rav) >= 0);
      default: c = ($signed(rav) < 0);
    endcase
    off = irv[18] ? int'(irv[18:0]) - 524288 : int'(irv[18:0]);
    e.br    = isbr;
    e.taken = isbr && c;
    e.pc    = e.taken ? pc_model + 32'(off) : pc_model;
    e.at    = cyc + (isbr ? 4 : 2);
    sb.push_back(e);
    ir = irv;
    ra_value = rav;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    if (ign && isbr) begin
      start = 1'b1;
      inc_pc = 1'b1;
      @(negedge clock);
      @(negedge clock);
      start = 1'b0;
      inc_pc = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rv;
    int          kind;
    clear = 1'b0; start = 1'b0; inc_pc = 1'b0; ir = '0; ra_value = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_pc", 64'(pc), 0);
    chk("reset_busy", 64'(busy), 0);
    chk("reset_done", 64'(done), 0);
    chk("reset_taken", 64'(taken), 0);
    @(negedge clock);
    clear = 1'b1;

    // Clear mid-CALC must discard the pending 0x40 -> 0x45 update.
    incs(64);
    @(negedge clock);
    ir = mk_br(2'b00, 19'd5); ra_value = '0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    #2 clear = 1'b0;
    #1;
    chk("midcalc_pc", 64'(pc), 0);
    chk("midcalc_busy", 64'(busy), 0);
    chk("midcalc_done", 64'(done), 0);
    chk("midcalc_taken", 64'(taken), 0);
    @(negedge clock);
    clear = 1'b1;
    pc_model = '0;
    repeat (5) @(negedge clock);
    chk("midcalc_no_update", 64'(pc), 0);

    do_reset(); incs(16);
    issue(mk_br(2'b00, 19'd5), 32'h0, 0);            // brzr taken -> 0x15
    do_reset(); incs(16);
    issue(mk_br(2'b01, 19'd5), 32'h0, 0);            // brnz not taken
    do_reset(); incs(32);
    issue(mk_br(2'b11, 19'h7FFFD), 32'h8000_0000, 0); // brmi taken -> 0x1D
    issue(mk_br(2'b10, 19'h7FFFD), 32'h8000_0000, 0); // brpl not taken
    issue(mk_br(2'b01, 19'd3), 32'h1, 1);            // ignored start/inc_pc while busy
    do_reset();
    issue(mk_br(2'b00, 19'h7FFFF), 32'h0, 0);        // pc -> 0xFFFFFFFF
    incs(1);                                          // wraps to 0
    issue({5'b00000, 27'h7FF_FFFF}, 32'h0, 0);       // bad opcode
    do_reset();
    issue(mk_br(2'b00, 19'd2), 32'h0, 0);
    issue(mk_br(2'b01, 19'd2), 32'h0, 0);
    issue(mk_br(2'b11, 19'd4), 32'hF000_0000, 0);
`ifdef BRANCH_STATS_EN
    chk("stats_br_3", 64'(br_count), 3);
    chk("stats_taken_2", 64'(taken_count), 2);
`endif

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: rv = '0;
        1: rv = $urandom;
        2: rv = $urandom | 32'h8000_0000;
        default: rv = $urandom & 32'h7FFF_FFFF;
      endcase
      case ($urandom_range(0, 5))
        0:       incs($urandom_range(1, 3));
        1:       issue({5'(($urandom_range(0, 30) + 19) % 32), 27'($urandom)}, rv, 0);
        default: issue(mk_br(2'($urandom), 19'($urandom)), rv, bit'($urandom_range(0, 1)));
      endcase
    end

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
